// File: rtl/mdu_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDOP_NONE  = 3'd0,
    MDOP_MULT  = 3'd1,
    MDOP_MULTU = 3'd2,
    MDOP_DIV   = 3'd3,
    MDOP_DIVU  = 3'd4,
    MDOP_MTHI  = 3'd5,
    MDOP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_md_op(input md_op_e op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) || (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit product and quotient/remainder for mult/multu/div/divu.
module mdu_core
  import mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] sa, sb;
  logic [63:0] sprod, uprod;
  logic        sgn;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur;

  assign sa    = {{32{a[31]}}, a};
  assign sb    = {{32{b[31]}}, b};
  assign sprod = sa * sb;
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign sgn      = (op == MDOP_DIV);
  assign a_mag    = (sgn && a[31]) ? -a : a;
  assign b_mag    = (sgn && b[31]) ? -b : b;
  assign div_zero = (b == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign uq       = a_mag / b_safe;
  assign ur       = a_mag % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MDOP_MULT:  {res_hi, res_lo} = sprod;
      MDOP_MULTU: {res_hi, res_lo} = uprod;
      MDOP_DIV, MDOP_DIVU: begin
        res_lo = (sgn && (a[31] ^ b[31])) ? -uq : uq;
        res_hi = (sgn && a[31]) ? -ur : ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency FSM, pending result registers and HI/LO.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      p_hi, p_lo;
  logic             p_we;
  logic [31:0]      c_hi, c_lo;
  logic             c_dz;

  mdu_core u_core (
    .op       (mdOp),
    .a        (srcA),
    .b        (srcB),
    .res_hi   (c_hi),
    .res_lo   (c_lo),
    .div_zero (c_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MDU_IDLE;
      count <= '0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      p_we  <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start && is_md_op(mdOp)) begin
            p_hi  <= c_hi;
            p_lo  <= c_lo;
            // Divide by zero still burns the full latency but leaves HI/LO alone.
            p_we  <= !(is_div_op(mdOp) && c_dz);
            count <= is_div_op(mdOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy  <= 1'b1;
            state <= MDU_BUSY;
          end else if (!start && mdOp == MDOP_MTHI) begin
            hi <= srcA;
          end else if (!start && mdOp == MDOP_MTLO) begin
            lo <= srcA;
          end
        end
        MDU_BUSY: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            if (p_we) begin
              hi <= p_hi;
              lo <= p_lo;
            end
            busy  <= 1'b0;
            state <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule
